// File: rtl/scan_pkg.sv
// Shared definitions for the threshold-scan sequencer: FSM states,
// register offsets within the bus window and the timing units.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_DAC = 3'd2,
        SETTLE   = 3'd3,
        GATE     = 3'd4,
        STORE    = 3'd5,
        DONE     = 3'd6
    } state_e;

    // Register offsets relative to BASE_ADDR
    localparam logic [7:0] OFF_CTRL      = 8'd0;
    localparam logic [7:0] OFF_START_LO  = 8'd1;
    localparam logic [7:0] OFF_START_HI  = 8'd2;
    localparam logic [7:0] OFF_STOP_LO   = 8'd3;
    localparam logic [7:0] OFF_STOP_HI   = 8'd4;
    localparam logic [7:0] OFF_STEP      = 8'd5;
    localparam logic [7:0] OFF_SETTLE    = 8'd6;
    localparam logic [7:0] OFF_WINDOW_LO = 8'd7;
    localparam logic [7:0] OFF_WINDOW_HI = 8'd8;
    localparam logic [7:0] OFF_STATUS    = 8'd9;
    localparam logic [7:0] OFF_LEVEL     = 8'd10;

    // Clock cycles per unit of the SETTLE and WINDOW registers
    localparam int unsigned SETTLE_UNIT = 256;
    localparam int unsigned WINDOW_UNIT = 1024;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous result FIFO. Head word is shown combinationally; a pop
// advances the head on the next edge. Push when full and pop when empty
// are ignored. DEPTH must be a power of two so the pointers wrap freely.
module scan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Autonomous threshold scan: steps the DAC from START to STOP, waits for
// the SPI load and a settle time, counts discriminator pulses over a gate
// window and pushes one count per step into the result FIFO.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int         DAC_W      = 12,
    parameter int         CNT_W      = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] BASE_ADDR  = 8'h40
) (
    input  logic             clock50Mhz,
    input  logic             reset,
    input  logic [7:0]       addr,
    input  logic [7:0]       data,
    input  logic             write,
    output logic [7:0]       data_out,
    output logic [DAC_W-1:0] dac_code,
    output logic             dac_load,
    input  logic             dac_ready,
    input  logic             count,
    input  logic             res_rd,
    output logic [CNT_W-1:0] res_data,
    output logic             res_valid,
    output logic             busy,
    output logic             done
);

    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TIMER_W = 26;

    // Configuration registers
    logic [DAC_W-1:0]   start_q;
    logic [DAC_W-1:0]   stop_q;
    logic [7:0]         step_q;
    logic [7:0]         settle_q;
    logic [15:0]        window_q;

    // FSM state and registered outputs
    state_e             state_q;
    logic [DAC_W-1:0]   code_q;
    logic [DAC_W-1:0]   dac_code_q;
    logic               dac_load_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               ovf_q;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         wait_cnt_q;
    logic               seen_low_q;
    logic [CNT_W-1:0]   pulse_cnt_q;
    logic [7:0]         data_out_q;

    // Pulse conditioning
    logic [1:0]         sync_q;
    logic               cnt_prev_q;
    logic               edge_s;

    // Bus decode
    logic [7:0]         offset_s;
    logic               in_range_s;
    logic               wr_ctrl_s;
    logic               start_req_s;
    logic               abort_req_s;
    logic               cfg_we_s;
    logic [7:0]         rd_data_s;

    // Step arithmetic and timer loads
    logic [7:0]         step_eff_s;
    logic [DAC_W:0]     next_sum_s;
    logic               last_point_s;
    logic [15:0]        window_eff_s;
    logic [TIMER_W-1:0] settle_cycles_s;
    logic [TIMER_W-1:0] window_cycles_s;

    // FIFO interface
    logic               push_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [LVL_W-1:0]   fifo_level_s;

    assign offset_s    = addr - BASE_ADDR;
    assign in_range_s  = (addr >= BASE_ADDR) && (offset_s <= OFF_LEVEL);
    assign wr_ctrl_s   = write && in_range_s && (offset_s == OFF_CTRL);
    assign start_req_s = wr_ctrl_s && data[0];
    assign abort_req_s = wr_ctrl_s && data[1];
    assign cfg_we_s    = write && in_range_s && !busy_q;

    assign step_eff_s      = (step_q == 8'd0) ? 8'd1 : step_q;
    assign next_sum_s      = {1'b0, code_q} + {{(DAC_W-7){1'b0}}, step_eff_s};
    assign last_point_s    = next_sum_s[DAC_W] || (next_sum_s[DAC_W-1:0] > stop_q);
    assign window_eff_s    = (window_q == 16'd0) ? 16'd1 : window_q;
    assign settle_cycles_s = TIMER_W'(settle_q) * TIMER_W'(SETTLE_UNIT);
    assign window_cycles_s = TIMER_W'(window_eff_s) * TIMER_W'(WINDOW_UNIT);

    assign edge_s = sync_q[1] & ~cnt_prev_q;

    // An abort on the same edge as a STORE suppresses the push
    assign push_s = (state_q == STORE) && !fifo_full_s && !abort_req_s;

    assign data_out  = data_out_q;
    assign dac_code  = dac_code_q;
    assign dac_load  = dac_load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = !fifo_empty_s;

    scan_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock50Mhz),
        .rst_i   (reset),
        .push_i  (push_s),
        .data_i  (pulse_cnt_q),
        .pop_i   (res_rd),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s),
        .head_o  (res_data)
    );

    // Configuration register writes, locked while a scan is running
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= 8'd1;
            settle_q <= 8'd0;
            window_q <= 16'd0;
        end else if (cfg_we_s) begin
            case (offset_s)
                OFF_START_LO:  start_q[7:0]       <= data;
                OFF_START_HI:  start_q[DAC_W-1:8] <= data[DAC_W-9:0];
                OFF_STOP_LO:   stop_q[7:0]        <= data;
                OFF_STOP_HI:   stop_q[DAC_W-1:8]  <= data[DAC_W-9:0];
                OFF_STEP:      step_q             <= data;
                OFF_SETTLE:    settle_q           <= data;
                OFF_WINDOW_LO: window_q[7:0]      <= data;
                OFF_WINDOW_HI: window_q[15:8]     <= data;
                default:       ;
            endcase
        end
    end

    // Readback multiplexer; anything outside the register window reads 0
    always_comb begin
        rd_data_s = 8'd0;
        if (in_range_s) begin
            case (offset_s)
                OFF_START_LO:  rd_data_s = start_q[7:0];
                OFF_START_HI:  rd_data_s = 8'(start_q[DAC_W-1:8]);
                OFF_STOP_LO:   rd_data_s = stop_q[7:0];
                OFF_STOP_HI:   rd_data_s = 8'(stop_q[DAC_W-1:8]);
                OFF_STEP:      rd_data_s = step_q;
                OFF_SETTLE:    rd_data_s = settle_q;
                OFF_WINDOW_LO: rd_data_s = window_q[7:0];
                OFF_WINDOW_HI: rd_data_s = window_q[15:8];
                OFF_STATUS:    rd_data_s = {4'b0000, err_q, ovf_q, done_q, busy_q};
                OFF_LEVEL:     rd_data_s = 8'(fifo_level_s);
                default:       rd_data_s = 8'd0;
            endcase
        end else begin
            rd_data_s = 8'd0;
        end
    end

    // Registered readback port
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            data_out_q <= 8'd0;
        end else begin
            data_out_q <= rd_data_s;
        end
    end

    // Two-flop synchronizer for the asynchronous pulse input plus edge history
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b00;
            cnt_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], count};
            cnt_prev_q <= sync_q[1];
        end
    end

    // Scan FSM with registered DAC, busy and status outputs
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            code_q      <= '0;
            dac_code_q  <= '0;
            dac_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            timer_q     <= '0;
            wait_cnt_q  <= 2'd0;
            seen_low_q  <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            dac_load_q <= 1'b0;
            if (abort_req_s) begin
                // Abort wins over everything, including a simultaneous start
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req_s) begin
                            if (start_q > stop_q) begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end else begin
                                code_q  <= start_q;
                                done_q  <= 1'b0;
                                err_q   <= 1'b0;
                                ovf_q   <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        dac_code_q <= code_q;
                        dac_load_q <= 1'b1;
                        wait_cnt_q <= 2'd0;
                        seen_low_q <= 1'b0;
                        state_q    <= WAIT_DAC;
                    end
                    WAIT_DAC: begin
                        // A ready that never drops within two cycles of the load
                        // means the frame finished before we could see it low
                        if (!dac_ready) begin
                            seen_low_q <= 1'b1;
                        end
                        if (wait_cnt_q != 2'd3) begin
                            wait_cnt_q <= wait_cnt_q + 2'd1;
                        end
                        if (dac_ready && (seen_low_q || (wait_cnt_q == 2'd1))) begin
                            if (settle_q == 8'd0) begin
                                pulse_cnt_q <= '0;
                                timer_q     <= window_cycles_s - TIMER_W'(1);
                                state_q     <= GATE;
                            end else begin
                                timer_q <= settle_cycles_s - TIMER_W'(1);
                                state_q <= SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (timer_q == '0) begin
                            pulse_cnt_q <= '0;
                            timer_q     <= window_cycles_s - TIMER_W'(1);
                            state_q     <= GATE;
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                    GATE: begin
                        if (edge_s && (pulse_cnt_q != '1)) begin
                            pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
                        end
                        if (timer_q == '0) begin
                            state_q <= STORE;
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                    STORE: begin
                        // A full FIFO stalls the scan rather than dropping a result
                        if (fifo_full_s) begin
                            ovf_q <= 1'b1;
                        end else if (last_point_s) begin
                            state_q <= DONE;
                        end else begin
                            code_q  <= next_sum_s[DAC_W-1:0];
                            state_q <= LOAD;
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: expected DAC codes and FIFO words are
// queued when a scan is launched; a monitor compares them against dac_load
// pulses and FIFO pops. Register/status checks are made directly.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        write;
    logic [7:0]  data_out;
    logic [11:0] dac_code;
    logic        dac_load;
    logic        dac_ready;
    logic        count;
    logic        res_rd;
    logic [31:0] res_data;
    logic        res_valid;
    logic        busy;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;

    logic [11:0] exp_codes [$];
    logic [31:0] exp_words [$];

    scan_sequencer #(
        .DAC_W      (12),
        .CNT_W      (32),
        .FIFO_DEPTH (16),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock50Mhz (clk),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .write      (write),
        .data_out   (data_out),
        .dac_code   (dac_code),
        .dac_load   (dac_load),
        .dac_ready  (dac_ready),
        .count      (count),
        .res_rd     (res_rd),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .busy       (busy),
        .done       (done)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] val);
        @(posedge clk); #1;
        addr  = BASE + off;
        data  = val;
        write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        addr  = 8'h00;
    endtask

    task automatic rd(input logic [7:0] off, output logic [7:0] val);
        @(posedge clk); #1;
        addr = BASE + off;
        @(posedge clk); #1;
        val  = data_out;
        addr = 8'h00;
    endtask

    task automatic rd_check(input string name, input logic [7:0] off, input logic [7:0] exp);
        logic [7:0] v;
        rd(off, v);
        check(name, {24'd0, v}, {24'd0, exp});
    endtask

    task automatic cfg(input logic [15:0] s, input logic [15:0] e, input logic [7:0] st,
                       input logic [7:0] se, input logic [15:0] w);
        wr(OFF_START_LO, s[7:0]);
        wr(OFF_START_HI, s[15:8]);
        wr(OFF_STOP_LO, e[7:0]);
        wr(OFF_STOP_HI, e[15:8]);
        wr(OFF_STEP, st);
        wr(OFF_SETTLE, se);
        wr(OFF_WINDOW_LO, w[7:0]);
        wr(OFF_WINDOW_HI, w[15:8]);
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            res_rd = 1'b1;
            @(posedge clk); #1;
            res_rd = 1'b0;
        end
    endtask

    // DAC model: ready drops after a load and returns 40 cycles later
    initial begin
        dac_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (dac_load === 1'b1) begin
                dac_ready = 1'b0;
                repeat (40) @(posedge clk);
                #1;
                dac_ready = 1'b1;
            end
        end
    end

    // Discriminator model: 8-cycle pulse every 64 cycles, i.e. 16 per 1024-cycle window
    initial begin
        count = 1'b0;
        forever begin
            repeat (56) @(posedge clk);
            #1 count = 1'b1;
            repeat (8) @(posedge clk);
            #1 count = 1'b0;
        end
    end

    // Monitor: compares every DAC load and every FIFO pop against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (dac_load === 1'b1) begin
                if (exp_codes.size() == 0) begin
                    check("dac_load_unexpected", {31'd0, dac_load}, 32'd0);
                end else begin
                    check("dac_code", {20'd0, dac_code}, {20'd0, exp_codes.pop_front()});
                end
            end
            if (res_rd === 1'b1 && res_valid === 1'b1) begin
                if (exp_words.size() == 0) begin
                    check("res_word_unexpected", {31'd0, res_valid}, 32'd0);
                end else begin
                    check("res_data", res_data, exp_words.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] st;
        reset = 1'b1;
        addr  = 8'h00;
        data  = 8'h00;
        write = 1'b0;
        res_rd = 1'b0;
        cycles(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dac_load", {31'd0, dac_load}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_dac_code", {20'd0, dac_code}, 32'd0);
        reset = 1'b0;
        cycles(2);
        rd_check("rst_step", OFF_STEP, 8'd1);
        rd_check("rst_status", OFF_STATUS, 8'h00);

        // Scan 100..103 step 1
        cfg(16'd100, 16'd103, 8'd1, 8'd0, 16'd1);
        for (int i = 100; i <= 103; i++) begin
            exp_codes.push_back(12'(i));
            exp_words.push_back(32'd16);
        end
        wr(OFF_CTRL, 8'h01);
        wait_done("t1_done", 20000);
        rd_check("t1_status", OFF_STATUS, 8'h02);
        rd_check("t1_level", OFF_LEVEL, 8'd4);
        pop_n(4);
        rd_check("t1_level_empty", OFF_LEVEL, 8'd0);

        // Step 4 from 10 stops before exceeding 20
        cfg(16'd10, 16'd20, 8'd4, 8'd0, 16'd1);
        exp_codes.push_back(12'd10);
        exp_codes.push_back(12'd14);
        exp_codes.push_back(12'd18);
        for (int i = 0; i < 3; i++) exp_words.push_back(32'd16);
        wr(OFF_CTRL, 8'h01);
        wait_done("t2_done", 20000);
        rd_check("t2_level", OFF_LEVEL, 8'd3);
        pop_n(3);

        // START > STOP: error, no load, no push
        cfg(16'd50, 16'd40, 8'd1, 8'd0, 16'd1);
        wr(OFF_CTRL, 8'h01);
        cycles(50);
        rd_check("t4_status", OFF_STATUS, 8'h0A);
        rd_check("t4_level", OFF_LEVEL, 8'd0);

        // Top of range: single point, no wrap; upper hi-byte bits ignored
        cfg(16'hFFFF, 16'hFFFF, 8'd5, 8'd0, 16'd1);
        rd_check("t3_start_hi", OFF_START_HI, 8'h0F);
        exp_codes.push_back(12'hFFF);
        exp_words.push_back(32'd16);
        wr(OFF_CTRL, 8'h01);
        wait_done("t3_done", 5000);
        rd_check("t3_status", OFF_STATUS, 8'h02);
        rd_check("t3_level", OFF_LEVEL, 8'd1);

        // Abort during GATE; start and config writes while busy are ignored
        cfg(16'd200, 16'd210, 8'd1, 8'd0, 16'd4);
        exp_codes.push_back(12'd200);
        wr(OFF_CTRL, 8'h01);
        cycles(150);
        wr(OFF_CTRL, 8'h01);
        wr(OFF_STOP_LO, 8'h00);
        wr(OFF_CTRL, 8'h02);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        cycles(5000);
        rd_check("abort_status", OFF_STATUS, 8'h00);
        rd_check("abort_level_kept", OFF_LEVEL, 8'd1);
        rd_check("busy_cfg_locked", OFF_STOP_LO, 8'd210);
        pop_n(1);

        // 18 points into a 16-deep FIFO: stall with ovf, then drain
        cfg(16'd0, 16'd17, 8'd1, 8'd0, 16'd1);
        for (int i = 0; i < 18; i++) begin
            exp_codes.push_back(12'(i));
            exp_words.push_back(32'd16);
        end
        wr(OFF_CTRL, 8'h01);
        st = 8'h00;
        for (int k = 0; k < 15000; k++) begin
            rd(OFF_STATUS, st);
            if (st[2]) break;
        end
        check("ovf_status", {24'd0, st}, 32'h05);
        rd_check("ovf_level", OFF_LEVEL, 8'd16);
        pop_n(3);
        wait_done("ovf_done", 5000);
        rd_check("ovf_final_status", OFF_STATUS, 8'h06);
        rd_check("ovf_final_level", OFF_LEVEL, 8'd15);
        pop_n(15);
        rd_check("ovf_drained", OFF_LEVEL, 8'd0);

        // Reset during WAIT_DAC with a word in the FIFO
        cfg(16'd300, 16'd300, 8'd1, 8'd0, 16'd1);
        exp_codes.push_back(12'd300);
        exp_words.push_back(32'd16);
        wr(OFF_CTRL, 8'h01);
        wait_done("t6_pre_done", 5000);
        cfg(16'd300, 16'd301, 8'd1, 8'd0, 16'd1);
        exp_codes.push_back(12'd300);
        wr(OFF_CTRL, 8'h01);
        cycles(10);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_mid_dac_load", {31'd0, dac_load}, 32'd0);
        exp_words.delete();
        cycles(3);
        reset = 1'b0;
        cycles(3000);
        rd_check("rst_mid_level", OFF_LEVEL, 8'd0);
        rd_check("rst_mid_step", OFF_STEP, 8'd1);
        rd_check("rst_mid_start", OFF_START_LO, 8'd0);
        rd_check("rst_mid_status", OFF_STATUS, 8'h00);

        check("codes_left", exp_codes.size(), 32'd0);
        check("words_left", exp_words.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
